// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a byte-wide single-port RAM between instruction fetch
// (IF) and load/store (LS). Multi-byte accesses are sequenced one byte per
// cycle and assembled/split little-endian. Requesters get one-cycle done
// pulses. A jump flush drops an in-flight fetch.
//
// Optional feature: define IO_FULL_STALL_EN to stall store bytes aimed at
// the I/O window while io_buffer_full is high. Without the macro,
// io_buffer_full is ignored.

module mem_arbiter #(
    parameter logic [31:0] IO_BASE = 32'h00030000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        jump_enable,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_inst,

    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [1:0]  ls_len,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,

    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,

    input  logic        io_buffer_full
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IF_RD = 3'd1,
        LS_RD = 3'd2,
        LS_WR = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state_q,    state_d;
    logic [2:0]  cnt_q,      cnt_d;       // current byte slot (reads run one past the last byte)
    logic [1:0]  nlast_q,    nlast_d;     // byte count minus one
    logic [31:0] addr_q,     addr_d;
    logic [31:0] wdata_q,    wdata_d;
    logic [31:0] buf_q,      buf_d;       // read assembly buffer
    logic        if_done_q,  if_done_d;
    logic        ls_done_q,  ls_done_d;
    logic [31:0] if_inst_q,  if_inst_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic [31:0] byte_addr;
    logic        rd_state;
    logic        slot_active;
    logic        is_io;
    logic        io_stall;
    logic [1:0]  cap_sel;
    logic [1:0]  wr_sel;

    // Address of the byte slot currently on the bus; wraps modulo 2^32.
    assign byte_addr = addr_q + {29'd0, cnt_q};
    assign rd_state  = (state_q == IF_RD) || (state_q == LS_RD);

    // Reads drive an address only for slots 0..N-1; the extra slot N just
    // collects the final byte from the RAM pipeline.
    assign slot_active = (rd_state && (cnt_q <= {1'b0, nlast_q})) || (state_q == LS_WR);

    assign is_io = (byte_addr[17:16] == IO_BASE[17:16]);

`ifdef IO_FULL_STALL_EN
    // Hold a store byte headed for a full I/O sink.
    assign io_stall = (state_q == LS_WR) && is_io && io_buffer_full;
`else
    logic unused_io;
    assign io_stall  = 1'b0;
    assign unused_io = is_io ^ io_buffer_full;
`endif

    // Slot N of a read captures byte N-1; slot 0 captures nothing.
    assign cap_sel = cnt_q[1:0] - 2'd1;
    assign wr_sel  = cnt_q[1:0];

    // Bus outputs are decoded from the registered slot so they stay stable
    // through a whole cycle and hold while rdy_in freezes the state.
    always_comb begin
        mem_a    = slot_active ? byte_addr : 32'd0;
        mem_dout = (state_q == LS_WR) ? wdata_q[{wr_sel, 3'b000} +: 8] : 8'd0;
        // The RAM is frozen by rdy_in too, but gate the strobe anyway so a
        // stalled cycle can never commit a write.
        mem_wr   = (state_q == LS_WR) && rdy_in && !io_stall;
    end

    assign if_done  = if_done_q;
    assign if_inst  = if_inst_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;

    // Next-state logic: arbitration, byte sequencing, read assembly, done pulses.
    always_comb begin
        // NOTE: every _d gets its hold value first; any path that forgets an
        // assignment then keeps the register instead of inferring a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        nlast_d    = nlast_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        if_done_d  = if_done_q;
        ls_done_d  = ls_done_q;
        if_inst_d  = if_inst_q;
        ls_rdata_d = ls_rdata_q;

        if (rdy_in) begin
            case (state_q)
                IDLE: begin
                    cnt_d = 3'd0;
                    buf_d = 32'd0;
                    if (ls_req) begin
                        // Load/store wins; a length code of 2 is widened to a word.
                        state_d = ls_wr ? LS_WR : LS_RD;
                        addr_d  = ls_addr;
                        wdata_d = ls_wdata;
                        nlast_d = (ls_len == 2'd2) ? 2'd3 : ls_len;
                    end else if (if_req && !jump_enable) begin
                        state_d = IF_RD;
                        addr_d  = if_addr;
                        nlast_d = 2'd3;
                    end
                end

                IF_RD, LS_RD: begin
                    if ((state_q == IF_RD) && jump_enable) begin
                        // Flushed fetch: abandon silently, no done pulse.
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                    end else begin
                        if (cnt_q != 3'd0) begin
                            buf_d[{cap_sel, 3'b000} +: 8] = mem_din;
                        end
                        if (cnt_q == ({1'b0, nlast_q} + 3'd1)) begin
                            state_d = DONE;
                            if (state_q == IF_RD) begin
                                if_done_d = 1'b1;
                                if_inst_d = buf_d;
                            end else begin
                                ls_done_d  = 1'b1;
                                ls_rdata_d = buf_d;
                            end
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end

                LS_WR: begin
                    if (!io_stall) begin
                        if (cnt_q[1:0] == nlast_q) begin
                            state_d   = DONE;
                            ls_done_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end

                DONE: begin
                    // One-cycle pulse; requests are not looked at here.
                    state_d   = IDLE;
                    cnt_d     = 3'd0;
                    if_done_d = 1'b0;
                    ls_done_d = 1'b0;
                end

                default: begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            nlast_q    <= 2'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            buf_q      <= 32'd0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_inst_q  <= 32'd0;
            ls_rdata_q <= 32'd0;
        end else begin
            // NOTE: non-blocking updates so every register samples the
            // pre-edge value of the others, independent of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nlast_q    <= nlast_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_inst_q  <= if_inst_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory controller that shares the byte-wide RAM bus between instruction fetch (IF) and the load/store stage (LS).
- Sequences multi-byte accesses one byte per cycle and assembles/splits words little-endian.
- Returns one-cycle done pulses to requesters.
- Drops in-flight IF fetches on a branch/jump flush, in step with the IF/ID flush.

Parameters:
- IO_BASE, 32'h00030000, start of memory-mapped I/O space; an address is I/O when addr[17:16]==2'b11.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset; synchronous, active-low
- rdy_in  in  1  global ready; 0 freezes all state
- jump_enable  in  1  EX redirect; aborts IF activity
- if_req  in  1  fetch request; held until if_done
- if_addr  in  32  fetch byte address
- if_done  out  1  one-cycle pulse; if_inst valid this cycle
- if_inst  out  32  fetched word
- ls_req  in  1  load/store request; held until ls_done
- ls_wr  in  1  1=store, 0=load
- ls_len  in  2  byte count minus 1 (0=byte, 1=half, 3=word; 2 illegal)
- ls_addr  in  32  start byte address
- ls_wdata  in  32  store data, low bytes used
- ls_done  out  1  one-cycle pulse; ls_rdata valid on loads
- ls_rdata  out  32  load data, zero-extended raw bytes
- mem_din  in  8  RAM read data
- mem_dout  out  8  RAM write data
- mem_a  out  32  RAM byte address
- mem_wr  out  1  RAM write enable
- io_buffer_full  in  1  I/O sink full; used only with the optional feature

Behaviour:
- Reset (rst_in==0 at a posedge): state IDLE; byte counter 0.
  - All outputs 0: if_done, ls_done, if_inst, ls_rdata, mem_a, mem_dout, mem_wr.
  - An in-flight access is abandoned with no done pulse.
- rdy_in==0: state, counters and data registers hold. mem_wr is gated to 0 while rdy_in==0. The RAM is frozen by the same rdy_in.
- States: IDLE, IF_RD, LS_RD, LS_WR, DONE.
- IDLE arbitration:
  - ls_req has priority over if_req.
  - if_req is ignored in any cycle where jump_enable==1.
  - Grant latches addr/len/wdata and moves to the op state at edge 0.
- RAM timing: mem_din returns the byte for the address driven in the previous cycle (1-cycle latency).
- Read of N bytes (IF always N=4):
  - Byte i address (addr+i) is driven in the cycle after edge i.
  - Byte i is captured into bits [8i+7:8i] at edge i+2.
  - At edge N+1 the FSM enters DONE and done/data are registered high.
  - Word read: done is high in the 6th cycle after the request edge.
- Write of N bytes:
  - Byte i is driven on mem_a/mem_dout with mem_wr=1 in the cycle after edge i.
  - At edge N the FSM enters DONE with ls_done=1 and mem_wr=0.
- DONE: lasts 1 cycle and requests are not sampled. At the next edge, done clears and the FSM returns to IDLE. A requester must deassert req by the end of its done cycle.
- Outside an active byte slot: mem_a=0, mem_dout=0, mem_wr=0.
- jump_enable==1 at an edge:
  - In IF_RD: abort to IDLE, no if_done.
  - In DONE for an IF op: if_done clears normally. IF ignores an if_done that coincides with jump_enable.
  - LS ops are never aborted.
- Address arithmetic: addr+i wraps modulo 2^32.
- ls_len==2: treated as 3.

Optional Feature:
- Macro IO_FULL_STALL_EN.
- Defined: in LS_WR with an I/O address, while io_buffer_full==1, the byte counter holds and mem_wr=0. The write resumes when io_buffer_full returns to 0.
- Undefined: io_buffer_full is ignored.

Test Plan:
- if_req=1, if_addr=0x100, RAM[0x100..0x103]=13,05,00,00 -> mem_a 0x100..0x103 on consecutive cycles; if_done high for exactly 1 cycle, 6 cycles after grant edge; if_inst=0x00000513.
- ls_req and if_req rise together, LS store word 0xDEADBEEF @0x200 -> LS granted first; mem_wr pulses with bytes EF,BE,AD,DE at 0x200..0x203; ls_done, then IF fetch starts after DONE.
- Load byte @0x7 with RAM[7]=0x80 -> ls_rdata=0x00000080, ls_done 3 cycles after grant.
- jump_enable=1 two cycles into IF_RD -> no if_done; next cycle state IDLE; fresh if_req served normally.
- rst_in=0 mid LS_WR (after 2 bytes) -> all outputs 0 next cycle, no ls_done. With IO_FULL_STALL_EN, a store byte to 0x30000 while io_buffer_full=1 for 5 cycles -> mem_wr stays 0 until io_buffer_full drops, then 1 write cycle.
- rdy_in=0 for 3 cycles mid word read -> mem_a held, mem_wr=0, result identical to the uninterrupted read.
